// File: rtl/adc_sample_buffer_pkg.sv
// Shared widths and types for the ADC sample buffer slice.
// Pure declarations: no logic, no latency, no flow control.
package adc_pkg;

  localparam int SAMPLE_W   = 12;
  localparam int FIFO_DEPTH = 8;
  localparam int LEVEL_W    = $clog2(FIFO_DEPTH) + 1;

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/adc_sample_buffer_if.sv
// Valid/ready sample stream from the buffer to its consumer.
// Master drives valid/data; slave drives ready; a beat moves when both are high.
interface adc_sample_buffer_if #(
  parameter int W = adc_pkg::SAMPLE_W
);

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/adc_sample_buffer_fifo.sv
// sample_fifo: generic FWFT FIFO with a registered head; push to visible head is one edge.
// Push while full is refused unless a pop happens on the same edge; pop while empty is ignored.
module sample_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] cnt;
  logic          do_pop;
  logic          do_push;

  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= push_dat;
    end
  end

  // head is registered so it holds the last popped value while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      head <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
      if (do_push && (empty || (do_pop && cnt == LW'(1)))) begin
        head <= push_dat;
      end else if (do_pop && cnt > LW'(1)) begin
        head <= mem[rptr + AW'(1)];
      end
    end
  end

endmodule

// File: rtl/adc_sample_buffer.sv
// Deserialises SPI ADC frames into a FWFT FIFO; sample visible one sck edge after write_en.
// Full FIFO drops new samples (sticky overflow) unless popped same edge; SAMPLE_AVG_EN adds avg_data.
module adc_sample_buffer
  import adc_pkg::*;
#(
  parameter int SAMPLE_W = adc_pkg::SAMPLE_W,
  parameter int DEPTH    = FIFO_DEPTH
) (
  input  logic                     sck,
  input  logic                     reset_n,
  input  logic                     sdi,
  input  logic                     reading,
  input  logic                     write_en,
  adc_sample_buffer_if.master      ob,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     frame_err,
  input  logic                     clr_flags,
  output logic [SAMPLE_W-1:0]      avg_data
);

  localparam int CW = $clog2(SAMPLE_W + 2);

  logic [SAMPLE_W-1:0] sr;
  logic [CW-1:0]       bcnt;
  logic                frame_ok;
  logic                frame_bad;
  logic                pop;
  logic                full;
  logic                empty;
  logic                drop;

  assign frame_ok  = write_en && (bcnt == CW'(SAMPLE_W));
  assign frame_bad = write_en && (bcnt != CW'(SAMPLE_W));
  assign pop       = ob.out_valid & ob.out_ready;
  assign drop      = frame_ok & full & ~pop;
  assign ob.out_valid = ~empty;

  // write_en wins over reading: the sdi bit on a strobe edge is not shifted in
  always_ff @(posedge sck or negedge reset_n) begin
    if (!reset_n) begin
      sr   <= '0;
      bcnt <= '0;
    end else if (write_en) begin
      bcnt <= '0;
    end else if (reading) begin
      sr <= {sr[SAMPLE_W-2:0], sdi};
      if (bcnt != CW'(SAMPLE_W + 1)) begin
        bcnt <= bcnt + CW'(1);
      end
    end
  end

  always_ff @(posedge sck or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= (overflow & ~clr_flags) | drop;
      frame_err <= (frame_err & ~clr_flags) | frame_bad;
    end
  end

  sample_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (sck),
    .rst_n    (reset_n),
    .push     (frame_ok),
    .push_dat (sr),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .head     (ob.out_data)
  );

`ifdef SAMPLE_AVG_EN
  logic [SAMPLE_W-1:0] hist [4];
  logic [SAMPLE_W+1:0] acc;
  logic                accepted;

  assign accepted = frame_ok & ~drop;

  // acc tracks the sum of the last four accepted samples; avg lags it by one edge
  always_ff @(posedge sck or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        hist[i] <= '0;
      end
      acc      <= '0;
      avg_data <= '0;
    end else begin
      if (accepted) begin
        hist[0] <= sr;
        for (int i = 1; i < 4; i++) begin
          hist[i] <= hist[i-1];
        end
        acc <= acc + {2'b00, sr} - {2'b00, hist[3]};
      end
      avg_data <= acc[SAMPLE_W+1:2];
    end
  end
`else
  assign avg_data = '0;
`endif

endmodule

// File: tb/tb_adc_sample_buffer.sv
// Directed plus randomized bench for adc_sample_buffer against a queue-based reference model.
module tb_adc_sample_buffer;
  import adc_pkg::*;

  localparam int W = SAMPLE_W;
  localparam int D = FIFO_DEPTH;

  logic                 sck = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 sdi = 1'b0;
  logic                 reading = 1'b0;
  logic                 write_en = 1'b0;
  logic                 clr_flags = 1'b0;
  logic [$clog2(D):0]   level;
  logic                 overflow;
  logic                 frame_err;
  logic [W-1:0]         avg_data;

  adc_sample_buffer_if #(.W(W)) ob ();

  adc_sample_buffer #(.SAMPLE_W(W), .DEPTH(D)) dut (
    .sck       (sck),
    .reset_n   (reset_n),
    .sdi       (sdi),
    .reading   (reading),
    .write_en  (write_en),
    .ob        (ob),
    .level     (level),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clr_flags (clr_flags),
    .avg_data  (avg_data)
  );

  always #5 sck = ~sck;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [W-1:0] mq[$];
  bit           bq[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] exp_data = '0;
  logic [W-1:0] exp_avg = '0;
  bit           exp_ovf = 1'b0;
  bit           exp_ferr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(ob.out_valid), 32'(mq.size() != 0));
    check({tag, ".data"}, 32'(ob.out_data), 32'(exp_data));
    check({tag, ".level"}, 32'(level), 32'(mq.size()));
    check({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
    check({tag, ".ferr"}, 32'(frame_err), 32'(exp_ferr));
    check({tag, ".avg"}, 32'(avg_data), 32'(exp_avg));
  endtask

  // one sck edge: drive inputs, advance the model, then compare just after the edge
  task automatic step(input bit rd, input bit sd, input bit we, input bit rdy, input bit clr);
    int           sum;
    bit           pop;
    bit           was_full;
    logic [W-1:0] v;
    reading = rd; sdi = sd; write_en = we; ob.out_ready = rdy; clr_flags = clr;
    sum = 0;
    foreach (hist[i]) sum += int'(hist[i]);
    pop = rdy && (mq.size() != 0);
    was_full = (mq.size() == D);
    if (clr) begin
      exp_ovf = 1'b0;
      exp_ferr = 1'b0;
    end
    if (pop) void'(mq.pop_front());
    if (we) begin
      if (bq.size() == W) begin
        v = '0;
        foreach (bq[i]) v = {v[W-2:0], bq[i]};
        if (was_full && !pop) exp_ovf = 1'b1;
        else begin
          mq.push_back(v);
          hist.push_back(v);
          if (hist.size() > 4) void'(hist.pop_front());
        end
      end else begin
        exp_ferr = 1'b1;
      end
      bq.delete();
    end else if (rd) begin
      bq.push_back(sd);
    end
`ifdef SAMPLE_AVG_EN
    exp_avg = W'(sum / 4);
`else
    exp_avg = '0;
`endif
    @(posedge sck);
    #1;
    if (mq.size() != 0) exp_data = mq[0];
    check_all("step");
  endtask

  function automatic bit rdy_of(input int rm);
    return (rm == 2) ? 1'($urandom) : (rm == 1);
  endfunction

  task automatic send_bits(input logic [31:0] val, input int n, input int rm);
    for (int i = n - 1; i >= 0; i--) step(1'b1, val[i], 1'b0, rdy_of(rm), 1'b0);
  endtask

  task automatic frame(input logic [31:0] val, input int n, input int rm, input bit clr);
    send_bits(val, n, rm);
    step(1'($urandom), 1'($urandom), 1'b1, rdy_of(rm), clr);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    mq.delete(); bq.delete(); hist.delete();
    exp_data = '0; exp_avg = '0; exp_ovf = 1'b0; exp_ferr = 1'b0;
    check_all("reset");
    #2 reset_n = 1'b1;
  endtask

  initial begin
    ob.out_ready = 1'b0;
    repeat (2) @(posedge sck);
    #1;
    check_all("por");
    @(negedge sck);
    reset_n = 1'b1;
    @(posedge sck);
    #1;

    // single complete frame, visible one edge after write_en
    frame(32'hA5C, 12, 0, 1'b0);
    check("a5c.valid", 32'(ob.out_valid), 32'd1);
    check("a5c.data", 32'(ob.out_data), 32'hA5C);
    check("a5c.level", 32'(level), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // short frame is rejected
    frame(32'h7FF, 11, 0, 1'b0);
    check("short.ferr", 32'(frame_err), 32'd1);
    check("short.level", 32'(level), 32'd0);
    check("short.valid", 32'(ob.out_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("short.clr", 32'(frame_err), 32'd0);

    // overfill by one, then drain in order
    for (int i = 1; i <= 9; i++) frame(32'(i), 12, 0, 1'b0);
    check("ovf.level", 32'(level), 32'd8);
    check("ovf.flag", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      check("ovf.order", 32'(ob.out_data), 32'(i));
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("ovf.empty", 32'(ob.out_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // push into a full FIFO while popping
    for (int i = 0; i < 8; i++) frame(32'h10 + 32'(i), 12, 0, 1'b0);
    send_bits(32'h0FF, 12, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("fullpop.level", 32'(level), 32'd8);
    check("fullpop.ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("fullpop.last", 32'(ob.out_data), 32'h0FF);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // reset in the middle of a frame
    send_bits(32'h2A, 6, 0);
    do_reset();
    frame(32'h800, 12, 0, 1'b0);
    check("post_rst.ferr", 32'(frame_err), 32'd0);
    check("post_rst.data", 32'(ob.out_data), 32'h800);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // running average sequence
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      frame(32'h100 * 32'(i), 12, 0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SAMPLE_AVG_EN
      case (i)
        1: check("avg1", 32'(avg_data), 32'h040);
        2: check("avg2", 32'(avg_data), 32'h0C0);
        3: check("avg3", 32'(avg_data), 32'h180);
        default: check("avg4", 32'(avg_data), 32'h280);
      endcase
`else
      check("avg_off", 32'(avg_data), 32'd0);
`endif
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // randomized frames, lengths, backpressure and flag clears
    for (int k = 0; k < 200; k++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : W;
      frame($urandom, n, 2, ($urandom_range(0, 15) == 0));
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'b0, 1'($urandom), ($urandom_range(0, 31) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_sample_buffer.md
ADC_SAMPLE_BUFFER -- requirements
Module: adc_sample_buffer

Interface
REQ-001 Parameter: SAMPLE_W, 12, bits per ADC conversion, MSB first.
REQ-002 Parameter: DEPTH, 8, FIFO entries; power of two, at least 2.
REQ-003 Port: sck  input  1  serial clock; all logic is on its rising edge.
REQ-004 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: sdi  input  1  ADC serial data out, stable at the rising edge of sck.
REQ-006 Port: reading  input  1  from the SPI sequencer; high while data bits are on sdi.
REQ-007 Port: write_en  input  1  from the SPI sequencer; one-cycle end-of-conversion strobe.
REQ-008 Port: out_valid  output  1  FIFO non-empty.
REQ-009 Port: out_ready  input  1  consumer accepts the head sample.
REQ-010 Port: out_data  output  SAMPLE_W  head sample, first-word fall-through.
REQ-011 Port: level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 Port: overflow  output  1  sticky; a sample was dropped because the FIFO was full.
REQ-013 Port: frame_err  output  1  sticky; write_en arrived with a bit count other than SAMPLE_W.
REQ-014 Port: clr_flags  input  1  synchronous clear of overflow and frame_err.
REQ-015 Port: avg_data  output  SAMPLE_W  running average; present only under the configuration macro.

Function
REQ-016 Deserialiser:
- Each rising edge with reading=1: shift register = {sr[SAMPLE_W-2:0], sdi}.
- Bit counter increments and saturates at SAMPLE_W+1.
REQ-017 On a write_en edge, the frame is checked:
- Counter equals SAMPLE_W: frame is complete.
- Otherwise: frame is discarded, frame_err is set, nothing is pushed.
- In both cases the counter clears on the same edge.
REQ-018 reading=1 and write_en=1 on the same edge: write_en takes priority; the sdi bit is ignored.
REQ-019 A complete frame pushes sr into the FIFO; level rises on the same edge, so out_valid is high one cycle after write_en.
REQ-020 Pop: occurs on an edge with out_valid=1 and out_ready=1; out_data shows the next entry afterwards.
REQ-021 Full FIFO with a complete frame and no pop: the sample is dropped and overflow is set; FIFO contents are unchanged.
REQ-022 Full FIFO with a complete frame and a pop on the same edge: both happen and level is unchanged.
REQ-023 Empty FIFO:
- out_valid=0 and out_data holds its last value.
- out_ready is ignored.
- A push while empty makes out_valid high on the next edge; there is no same-cycle bypass.
REQ-024 Read and write pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-025 clr_flags takes effect on its edge. If a set event happens on the same edge, the flag ends up set.

Reset
REQ-026 reset_n=0 asynchronously clears:
- pointers, level, bit counter, shift register
- overflow, frame_err
- out_valid, out_data, avg_data
REQ-027 Reset in the middle of a frame discards the partial frame. The first frame after reset release is checked normally.

Configuration
REQ-028 Macro: SAMPLE_AVG_EN.
REQ-029 Defined:
- avg_data = (sum of the last 4 pushed samples) >> 2, using a SAMPLE_W+2 accumulator.
- It updates one edge after each push.
- Before 4 pushes, missing entries count as zero.
- Dropped and errored frames are excluded.
REQ-030 Undefined: avg_data is tied to 0 and no averaging registers exist.

Structure
REQ-031 Package adc_pkg holds:
- constant SAMPLE_W
- typedef sample_t (logic [SAMPLE_W-1:0])
- constant FIFO_DEPTH
REQ-032 The FIFO is a sub-module, sample_fifo: push, pop, full, empty and level, with no knowledge of framing.

Verification
REQ-033 Frame 0xA5C with reading high for 12 edges, then write_en: out_valid=1 and out_data=0xA5C on the next edge; level=1.
REQ-034 Frame with 11 bits then write_en: frame_err=1, level=0, out_valid=0; clr_flags returns frame_err to 0.
REQ-035 9 complete frames (0x001..0x009) with out_ready=0: level=8, overflow=1, pops return 0x001..0x008 in order.
REQ-036 FIFO full, push 0x0FF while out_ready=1: level stays 8, overflow stays 0, the last pop returns 0x0FF.
REQ-037 reset_n pulsed low after 6 bits of a frame: all outputs 0; the next full 12-bit frame 0x800 is accepted with no error.
REQ-038 With SAMPLE_AVG_EN, push 0x100, 0x200, 0x300, 0x400: avg_data reads 0x040, 0x0C0, 0x180, 0x280 after each push.
